data_mem_arbiter: RTL

//  Shares one single-port data memory (combinational read, write on clock edge) between two requesters:

---
 rtl/data_mem_arbiter_pkg.sv | 17 +
 rtl/data_mem_arbiter_picker.sv | 16 +
 rtl/data_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and the arbitration rule for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_SERVE = 2'b01,
    ARB_RESP  = 2'b10
  } arb_state_t;

  // On a tie, round-robin hands the slot to the port that did not win last time.
  function automatic logic pick_port(input logic r0, input logic r1,
                                     input logic last_winner, input logic fixed_priority);
    if (r0 && r1) return fixed_priority ? 1'b0 : ~last_winner;
    return r1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_picker.sv
// Combinational winner selection between the CPU port (0) and the loader port (1).
module mem_arb_picker
  import data_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  input  logic fixed_priority,
  output logic pick_valid,
  output logic pick_id
);

  assign pick_valid = req0 | req1;
  assign pick_id    = pick_port(req0, req1, last_winner, fixed_priority);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU control unit and a host/debug loader.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int Data_WIDTH       = 8,
  parameter int Data_Memory_Size = 256,
  parameter int DATA_ADDR_WIDTH  = $clog2(Data_Memory_Size),
  parameter bit FIXED_PRIORITY   = 1'b0,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                       clock,
  input  logic                       reset_bt,
  input  logic                       req0,
  input  logic                       req1,
  input  logic [DATA_ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_ADDR_WIDTH-1:0] addr1,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [Data_WIDTH-1:0]      wdata0,
  input  logic [Data_WIDTH-1:0]      wdata1,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic [Data_WIDTH-1:0]      rdata0,
  output logic [Data_WIDTH-1:0]      rdata1,
  output logic                       rvalid0,
  output logic                       rvalid1,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic                       mem_write_en,
  output logic [Data_WIDTH-1:0]      mem_data_in,
  input  logic [Data_WIDTH-1:0]      mem_data_out,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       gnt_cnt0,
  output logic [CNT_WIDTH-1:0]       gnt_cnt1
);

  arb_state_t                 state;
  logic                       last_winner;
  logic                       cur_id;
  logic                       cur_we;
  logic                       write_pend;
  logic                       pick_valid;
  logic                       pick_id;
  logic [DATA_ADDR_WIDTH-1:0] pick_addr;
  logic [Data_WIDTH-1:0]      pick_wdata;
  logic                       pick_we;

  mem_arb_picker u_picker (
    .req0           (req0),
    .req1           (req1),
    .last_winner    (last_winner),
    .fixed_priority (FIXED_PRIORITY),
    .pick_valid     (pick_valid),
    .pick_id        (pick_id)
  );

  assign pick_addr  = pick_id ? addr1  : addr0;
  assign pick_wdata = pick_id ? wdata1 : wdata0;
  assign pick_we    = pick_id ? we1    : we0;

  // Reset on the closing edge of a write slot must stop the commit, so gate it here.
  assign mem_write_en = write_pend & ~reset_bt;
  assign busy         = (state == ARB_SERVE) || (state == ARB_RESP);

  // mem_addr/mem_data_in double as the request latches and hold while idle.
  always_ff @(posedge clock) begin
    if (reset_bt) begin
      state       <= ARB_IDLE;
      last_winner <= 1'b1;
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      write_pend  <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      gnt_cnt0    <= '0;
      gnt_cnt1    <= '0;
    end else begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      write_pend <= 1'b0;
      case (state)
        ARB_SERVE: begin
          if (!cur_we) begin
            if (cur_id) begin
              rdata1  <= mem_data_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_data_out;
              rvalid0 <= 1'b1;
            end
          end
          state <= ARB_RESP;
        end
        ARB_IDLE, ARB_RESP: begin
          if (pick_valid) begin
            last_winner <= pick_id;
            cur_id      <= pick_id;
            cur_we      <= pick_we;
            write_pend  <= pick_we;
            mem_addr    <= pick_addr;
            mem_data_in <= pick_wdata;
            if (pick_id) begin
              gnt1 <= 1'b1;
              if (gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_WIDTH'(1);
            end else begin
              gnt0 <= 1'b1;
              if (gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_WIDTH'(1);
            end
            state <= ARB_SERVE;
          end else begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
